led_panel_rx: RTL and testbench
===============================

LED_PANEL_RX -- requirements
Module: led_panel_rx

Interface
REQ-001 Parameter: COLS, 64, number of columns shifted per row; the design supports only 64, and rd_col is 6 bits.
REQ-002 Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- red_in / green_in / blue_in  in  1 each  serial pixel data from the panel driver.
- sclk_in  in  1  shift clock.
- latch_in  in  1  latch strobe, active-low.
- blank_in  in  1  blank, active-high.
- aclk_in  in  1  row-advance clock.
- arst_in  in  1  row reset, active-high.
- rowmax_in  in  3  row-count upper bits; wrap occurs at {rowmax_in,3'b111}.
- rd_col  in  6  readout column address.
- clr_err  in  1  clears col_err.
- rd_rgb  out  3  {r,g,b} of the displayed row at rd_col.
- row_out  out  6  current row index.
- lit  out  1  panel illuminated (not blanked).
- line_stb  out  1  one-cycle pulse per latch event.
- frame_stb  out  1  one-cycle pulse when the row index returns to 0.
- last_cols  out  8  columns shifted before the most recent latch.
- col_err  out  1  sticky flag: last_cols was not equal to 64.

Function
REQ-003 Synchronisation:
- Each of the 8 panel inputs passes through a 2-flop synchroniser followed by a third history flop.
- An edge is detected when stage 2 differs from the history flop.
- Edge-driven state updates on the clk edge after detection, i.e. 3 clk edges after the input change.
REQ-004 Timing: the driver holds each sclk level and data for at least 3 clk periods; behaviour below this is undefined.
REQ-005 Shift:
- On each detected sclk rising edge, the synchronised red/green/blue shift into 64-bit registers: sreg <= {bit, sreg[63:1]}.
- After 64 shifts, the first-shifted bit occupies column 0.
REQ-006 Column counter: 8 bits, increments per sclk rising edge, saturates at 255 and never wraps.
REQ-007 Latch (detected latch_in falling edge):
- All three shift registers copy into display registers.
- last_cols takes the column count; the column count clears to 0.
- line_stb pulses for 1 cycle.
REQ-008 Column error: if the latched count is not 64, col_err is set; it stays set until clr_err=1. If set and clear occur in the same cycle, set wins.
REQ-009 Shift and latch in the same cycle: the shift completes first, and the latch captures the post-shift contents and count+1.
REQ-010 Column count preservation: the column count is not cleared by blank, aclk or arst.
REQ-011 lit = NOT synchronised blank_in (stage 2); no edge-detect delay applies.
REQ-012 Row state machine, states IDLE and SCAN:
- Any detected arst_in level=1 forces row_out=0 and state IDLE.
- IDLE -> SCAN when arst_in is synchronised low.
- In SCAN, a detected aclk rising edge increments row_out.
- In SCAN, if row_out=={rowmax_in,3'b111} when aclk rises, row_out wraps to 0 and frame_stb pulses.
- The transition of arst from 0 to 1 also pulses frame_stb once.
REQ-013 aclk and arst in the same cycle: arst wins, row_out=0, and frame_stb pulses exactly once.
REQ-014 aclk rising in IDLE is ignored.
REQ-015 Readout: rd_rgb is registered, with 1-cycle latency from rd_col.
REQ-016 Readout during latch: if a latch updates the display in the same cycle as a read, rd_rgb returns the old data; the new data appears on the next read.

Reset
REQ-017 While reset=0, asynchronously:
- row_out=0, lit=0, line_stb=0, frame_stb=0, last_cols=0, col_err=0, rd_rgb=0.
- Shift and display registers are 0; column count is 0; state is IDLE.
- Synchroniser stages take the idle levels: sclk 0, latch 1, blank 1, aclk 0, arst 1.
REQ-018 Reset mid-row discards the partial shift contents; after release, the first full row latches with last_cols=64 and col_err=0.

Verification
REQ-019 Normal row: 64 sclk pulses with alternating red=1/0 starting at 1, then latch low -> line_stb once, last_cols=64, col_err=0, rd_col=0 gives rgb[2]=1, rd_col=1 gives rgb[2]=0.
REQ-020 Short row: 63 sclk pulses then latch -> last_cols=63, col_err=1; pulse clr_err -> col_err=0.
REQ-021 Row wrap: arst pulse, then 16 aclk pulses with rowmax_in=3'b001 -> row_out runs 1..15 then 0, frame_stb asserts once at the wrap (plus once at the arst).
REQ-022 Collision: aclk rise and arst rise in the same synchronised cycle -> row_out=0, exactly one frame_stb.
REQ-023 Overrun: 300 sclk pulses then latch -> last_cols=255 (saturated), col_err=1.
REQ-024 Reset mid-row: assert reset after 20 shifts, release, send a full 64-column row -> last_cols=64, and all outputs equal their REQ-017 values while reset is held.

Source files
------------

// File: rtl/led_panel_rx.sv
`default_nettype none
// ============================================================================
//  Module      : led_panel_rx
//  Description : Receiver for a serial LED panel drive bus. It synchronises
//                the panel control/data lines, rebuilds each shifted row into
//                a 64-column display buffer with random-access readout, and
//                tracks the scanned row index, with column-count error
//                detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_panel_rx #(
    parameter int COLS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       red_in,
    input  logic       green_in,
    input  logic       blue_in,
    input  logic       sclk_in,
    input  logic       latch_in,
    input  logic       blank_in,
    input  logic       aclk_in,
    input  logic       arst_in,
    input  logic [2:0] rowmax_in,
    input  logic [5:0] rd_col,
    input  logic       clr_err,
    output logic [2:0] rd_rgb,
    output logic [5:0] row_out,
    output logic       lit,
    output logic       line_stb,
    output logic       frame_stb,
    output logic [7:0] last_cols,
    output logic       col_err
);

    // Bit positions of the panel lines inside the synchroniser vectors
    localparam int c_I_RED   = 0;
    localparam int c_I_GRN   = 1;
    localparam int c_I_BLU   = 2;
    localparam int c_I_SCLK  = 3;
    localparam int c_I_LATCH = 4;
    localparam int c_I_BLANK = 5;
    localparam int c_I_ACLK  = 6;
    localparam int c_I_ARST  = 7;

    // Idle bus levels: arst=1, aclk=0, blank=1, latch=1, sclk=0, rgb=0
    localparam logic [7:0] c_SYNC_IDLE = 8'b1011_0000;
    localparam logic [7:0] c_COLS      = 8'(COLS);
    localparam logic [7:0] c_CNT_MAX   = 8'hFF;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SCAN = 1'b1;

    logic [7:0]      w_async;
    logic [7:0]      r_sync1;
    logic [7:0]      r_sync2;
    logic [7:0]      r_hist;

    logic            w_sclk_rise;
    logic            w_latch_fall;
    logic            w_aclk_rise;
    logic            w_arst_rise;
    logic            w_arst_lvl;

    logic [COLS-1:0] r_sreg_r;
    logic [COLS-1:0] r_sreg_g;
    logic [COLS-1:0] r_sreg_b;
    logic [COLS-1:0] r_disp_r;
    logic [COLS-1:0] r_disp_g;
    logic [COLS-1:0] r_disp_b;
    logic [COLS-1:0] w_shift_r;
    logic [COLS-1:0] w_shift_g;
    logic [COLS-1:0] w_shift_b;

    logic [7:0]      r_col_cnt;
    logic [7:0]      w_cnt_next;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [5:0]      w_row_max;
    logic            w_row_clr;
    logic            w_row_step;
    logic            w_row_wrap;
    logic            w_frame;

    assign w_async = {arst_in, aclk_in, blank_in, latch_in,
                      sclk_in, blue_in, green_in, red_in};

    // Two-flop synchroniser plus a history stage for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= c_SYNC_IDLE;
            r_sync2 <= c_SYNC_IDLE;
            r_hist  <= c_SYNC_IDLE;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_sclk_rise  =  r_sync2[c_I_SCLK]  & ~r_hist[c_I_SCLK];
    assign w_latch_fall = ~r_sync2[c_I_LATCH] &  r_hist[c_I_LATCH];
    assign w_aclk_rise  =  r_sync2[c_I_ACLK]  & ~r_hist[c_I_ACLK];
    assign w_arst_rise  =  r_sync2[c_I_ARST]  & ~r_hist[c_I_ARST];
    assign w_arst_lvl   =  r_sync2[c_I_ARST];

    // Blank acts on the synchronised level directly, no edge delay
    assign lit = ~r_sync2[c_I_BLANK];

    // Post-shift register images; a latch in the same cycle captures these
    assign w_shift_r = {r_sync2[c_I_RED], r_sreg_r[COLS-1:1]};
    assign w_shift_g = {r_sync2[c_I_GRN], r_sreg_g[COLS-1:1]};
    assign w_shift_b = {r_sync2[c_I_BLU], r_sreg_b[COLS-1:1]};

    // Saturating column count including a shift landing this cycle
    always_comb begin
        w_cnt_next = r_col_cnt;
        if (w_sclk_rise && (r_col_cnt != c_CNT_MAX)) begin
            w_cnt_next = r_col_cnt + 8'd1;
        end
    end

    // Shift registers, display buffer, column count and latch strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg_r  <= '0;
            r_sreg_g  <= '0;
            r_sreg_b  <= '0;
            r_disp_r  <= '0;
            r_disp_g  <= '0;
            r_disp_b  <= '0;
            r_col_cnt <= '0;
            last_cols <= '0;
            line_stb  <= 1'b0;
        end else begin
            line_stb <= w_latch_fall;
            if (w_sclk_rise) begin
                r_sreg_r <= w_shift_r;
                r_sreg_g <= w_shift_g;
                r_sreg_b <= w_shift_b;
            end
            if (w_latch_fall) begin
                r_disp_r  <= w_sclk_rise ? w_shift_r : r_sreg_r;
                r_disp_g  <= w_sclk_rise ? w_shift_g : r_sreg_g;
                r_disp_b  <= w_sclk_rise ? w_shift_b : r_sreg_b;
                last_cols <= w_cnt_next;
                r_col_cnt <= '0;
            end else begin
                r_col_cnt <= w_cnt_next;
            end
        end
    end

    // Sticky column error; a new error outranks a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_err <= 1'b0;
        end else if (w_latch_fall && (w_cnt_next != c_COLS)) begin
            col_err <= 1'b1;
        end else if (clr_err) begin
            col_err <= 1'b0;
        end
    end

    // Registered readout; a same-cycle latch is seen on the following read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_rgb <= '0;
        end else begin
            rd_rgb <= {r_disp_r[rd_col], r_disp_g[rd_col], r_disp_b[rd_col]};
        end
    end

    // Row FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Row FSM next state: arst level holds IDLE, its release enters SCAN
    always_comb begin
        w_state_next = r_state;
        if (w_arst_lvl) begin
            w_state_next = c_ST_IDLE;
        end else if (r_state == c_ST_IDLE) begin
            w_state_next = c_ST_SCAN;
        end
    end

    assign w_row_max = {rowmax_in, 3'b111};

    // Row FSM outputs: clear, step and wrap decisions (arst dominates aclk)
    always_comb begin
        w_row_clr  = w_arst_lvl;
        w_row_step = (r_state == c_ST_SCAN) && w_aclk_rise && !w_arst_lvl;
        w_row_wrap = w_row_step && (row_out == w_row_max);
        w_frame    = w_arst_rise || w_row_wrap;
    end

    // Row index and frame strobe registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_out   <= '0;
            frame_stb <= 1'b0;
        end else begin
            frame_stb <= w_frame;
            if (w_row_clr || w_row_wrap) begin
                row_out <= '0;
            end else if (w_row_step) begin
                row_out <= row_out + 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_panel_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_panel_rx
//  Description : Self-checking bench for led_panel_rx against a behavioural
//                model of the panel bus (pixel history queue, row counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_panel_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       red_in, green_in, blue_in;
    logic       sclk_in, latch_in, blank_in, aclk_in, arst_in;
    logic [2:0] rowmax_in;
    logic [5:0] rd_col;
    logic       clr_err;
    logic [2:0] rd_rgb;
    logic [5:0] row_out;
    logic       lit, line_stb, frame_stb;
    logic [7:0] last_cols;
    logic       col_err;

    led_panel_rx #(.COLS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .red_in    (red_in),
        .green_in  (green_in),
        .blue_in   (blue_in),
        .sclk_in   (sclk_in),
        .latch_in  (latch_in),
        .blank_in  (blank_in),
        .aclk_in   (aclk_in),
        .arst_in   (arst_in),
        .rowmax_in (rowmax_in),
        .rd_col    (rd_col),
        .clr_err   (clr_err),
        .rd_rgb    (rd_rgb),
        .row_out   (row_out),
        .lit       (lit),
        .line_stb  (line_stb),
        .frame_stb (frame_stb),
        .last_cols (last_cols),
        .col_err   (col_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_line   = 0;
    int n_frame  = 0;

    // Reference model state
    logic [2:0] hist[$];
    logic [2:0] exp_disp[64];
    int         m_cnt;
    int         exp_last;
    logic       exp_err;
    int         exp_lines;
    int         m_row;
    int         m_frames;
    bit         m_scan;

    // Strobe pulse counters
    always @(negedge clk) begin
        if (line_stb)  n_line++;
        if (frame_stb) n_frame++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_shift(input logic [2:0] v);
        hist.push_back(v);
        if (m_cnt < 255) m_cnt++;
    endfunction

    function automatic void model_latch();
        for (int c = 0; c < 64; c++) begin
            int idx;
            idx = hist.size() - 64 + c;
            exp_disp[c] = (idx >= 0) ? hist[idx] : 3'b000;
        end
        exp_last = m_cnt;
        if (m_cnt != 64) exp_err = 1'b1;
        m_cnt = 0;
        exp_lines++;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int c = 0; c < 64; c++) exp_disp[c] = 3'b000;
        m_cnt = 0; exp_last = 0; exp_err = 1'b0; m_row = 0;
    endfunction

    task automatic shift(input logic [2:0] v);
        {red_in, green_in, blue_in} = v;
        sclk_in = 1'b1;
        model_shift(v);
        tick(3);
        sclk_in = 1'b0;
        tick(3);
    endtask

    task automatic do_latch();
        latch_in = 1'b0;
        model_latch();
        tick(3);
        latch_in = 1'b1;
        tick(3);
    endtask

    task automatic aclk_pulse();
        aclk_in = 1'b1;
        if (m_scan) begin
            if (m_row == (int'(rowmax_in) * 8 + 7)) begin
                m_row = 0;
                m_frames++;
            end else begin
                m_row++;
            end
        end
        tick(3);
        aclk_in = 1'b0;
        tick(3);
    endtask

    task automatic arst_pulse();
        arst_in = 1'b1;
        m_scan = 0; m_row = 0; m_frames++;
        tick(3);
        arst_in = 1'b0;
        tick(4);
        m_scan = 1;
    endtask

    task automatic check_row(input string tag);
        check({tag, "_lines"}, n_line, exp_lines);
        check({tag, "_last_cols"}, last_cols, exp_last);
        check({tag, "_col_err"}, col_err, exp_err);
        for (int c = 0; c < 64; c++) begin
            rd_col = 6'(c);
            tick(1);
            check($sformatf("%s_col%0d", tag, c), rd_rgb, exp_disp[c]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_rgb"},    rd_rgb,    3'b000);
        check({tag, "_row_out"},   row_out,   6'd0);
        check({tag, "_lit"},       lit,       1'b0);
        check({tag, "_line_stb"},  line_stb,  1'b0);
        check({tag, "_frame_stb"}, frame_stb, 1'b0);
        check({tag, "_last_cols"}, last_cols, 8'd0);
        check({tag, "_col_err"},   col_err,   1'b0);
    endtask

    initial begin
        reset = 1'b0;
        {red_in, green_in, blue_in} = 3'b000;
        sclk_in = 1'b0; latch_in = 1'b1; blank_in = 1'b1;
        aclk_in = 1'b0; arst_in = 1'b0;
        rowmax_in = 3'b000; rd_col = 6'd0; clr_err = 1'b0;
        exp_lines = 0; m_frames = 0; m_scan = 1;
        model_reset();

        // Reset values
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b1;
        tick(5);

        // Normal row: red alternates 1,0 starting at 1, green/blue random
        for (int i = 0; i < 64; i++) begin
            logic [2:0] v;
            v = 3'($urandom);
            v[2] = ((i % 2) == 0);
            shift(v);
        end
        do_latch();
        rd_col = 6'd0; tick(1);
        check("normal_col0_red", rd_rgb[2], 1'b1);
        rd_col = 6'd1; tick(1);
        check("normal_col1_red", rd_rgb[2], 1'b0);
        check_row("normal");

        // Fully random row
        for (int i = 0; i < 64; i++) shift(3'($urandom));
        do_latch();
        check_row("random");

        // Short row, then clear the sticky error
        for (int i = 0; i < 63; i++) shift(3'($urandom));
        do_latch();
        check_row("short");
        clr_err = 1'b1; tick(1); clr_err = 1'b0; exp_err = 1'b0;
        tick(1);
        check("short_clr", col_err, exp_err);

        // 63 shifts, then the 64th shift and the latch detected together
        for (int i = 0; i < 63; i++) shift(3'($urandom));
        begin
            logic [2:0] v;
            v = 3'($urandom);
            {red_in, green_in, blue_in} = v;
            sclk_in = 1'b1; latch_in = 1'b0;
            model_shift(v);
            model_latch();
            tick(3);
            sclk_in = 1'b0; latch_in = 1'b1;
            tick(3);
        end
        check_row("shift_latch");

        // Overrun: column count saturates
        for (int i = 0; i < 300; i++) shift(3'($urandom));
        do_latch();
        check_row("overrun");
        clr_err = 1'b1; tick(1); clr_err = 1'b0; exp_err = 1'b0;
        tick(1);
        check("overrun_clr", col_err, exp_err);

        // lit follows blank
        blank_in = 1'b0; tick(3);
        check("lit_on", lit, 1'b1);
        blank_in = 1'b1; tick(3);
        check("lit_off", lit, 1'b0);
        blank_in = 1'b0; tick(3);

        // Row wrap with rowmax=1: rows 1..15 then 0
        rowmax_in = 3'b001;
        arst_pulse();
        check("wrap_arst_row", row_out, m_row);
        check("wrap_arst_frames", n_frame, m_frames);
        for (int i = 0; i < 16; i++) begin
            aclk_pulse();
            check($sformatf("wrap_row%0d", i), row_out, m_row);
        end
        check("wrap_frames", n_frame, m_frames);

        // Collision of aclk and arst rising in the same cycle
        aclk_pulse(); aclk_pulse(); aclk_pulse();
        check("coll_pre_row", row_out, m_row);
        aclk_in = 1'b1; arst_in = 1'b1;
        m_scan = 0; m_row = 0; m_frames++;
        tick(3);
        check("coll_row", row_out, m_row);
        aclk_in = 1'b0; tick(3);
        check("coll_frames", n_frame, m_frames);
        // aclk while held in IDLE is ignored
        aclk_pulse();
        check("idle_aclk_row", row_out, m_row);
        arst_in = 1'b0; tick(4); m_scan = 1;
        aclk_pulse(); aclk_pulse();
        check("post_coll_row", row_out, m_row);
        check("post_coll_frames", n_frame, m_frames);

        // Reset mid-row with nonzero outputs beforehand
        for (int i = 0; i < 10; i++) shift(3'b111);
        do_latch();
        check("pre_reset_err", col_err, 1'b1);
        rd_col = 6'd63;
        for (int i = 0; i < 20; i++) shift(3'($urandom));
        reset = 1'b0;
        {red_in, green_in, blue_in} = 3'b000;
        blank_in = 1'b1;
        model_reset();
        tick(3);
        check_reset_outputs("midrow_reset");
        reset = 1'b1;
        blank_in = 1'b0;
        tick(5);
        for (int i = 0; i < 64; i++) shift(3'($urandom));
        do_latch();
        check_row("after_reset");
        check("final_frames", n_frame, m_frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
